shift_reg_bank: RTL and testbench

SHIFT_REG_BANK -- requirements
Module: shift_reg_bank

---
 rtl/shift_reg_bank_pkg.sv | 15 +
 rtl/shift_reg_stage.sv | 34 +++
 rtl/shift_reg_bank.sv | 91 +++++++++
 tb/tb_shift_reg_bank.sv | 177 +++++++++++++++++
 4 files changed

// File: rtl/shift_reg_bank_pkg.sv
// Shared mode encodings and the fill-counter width helper for shift_reg_bank.
package shift_reg_bank_pkg;

   typedef enum logic [1:0] {
      MODE_HOLD = 2'b00,
      MODE_SHL  = 2'b01,
      MODE_SHR  = 2'b10,
      MODE_LOAD = 2'b11
   } mode_t;

   function automatic int fill_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/shift_reg_stage.sv
// One WIDTH-bit bank stage: hold/left/right/load mux into a falling-edge flop.
module shift_reg_stage
   import shift_reg_bank_pkg::*;
#(
   parameter int WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  mode_t            sel,
   input  logic [WIDTH-1:0] left,
   input  logic [WIDTH-1:0] right,
   input  logic [WIDTH-1:0] load,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] nxt;

   always_comb begin
      nxt = q;
      case (sel)
         MODE_HOLD: nxt = q;
         MODE_SHL:  nxt = left;
         MODE_SHR:  nxt = right;
         MODE_LOAD: nxt = load;
         default:   nxt = q;
      endcase
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) q <= '0;
      else       q <= nxt;
   end

endmodule

// File: rtl/shift_reg_bank.sv
// Bank of DEPTH shift stages with a saturating fill counter, clocked on the falling edge.
// Define SHIFT_REG_BANK_ROTATE_EN to add the rot input for rotating shifts.
module shift_reg_bank
   import shift_reg_bank_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DEPTH = 4
) (
   input  logic                          clk,
   input  logic                          reset,
   input  logic [1:0]                    mode,
`ifdef SHIFT_REG_BANK_ROTATE_EN
   input  logic                          rot,
`endif
   input  logic [WIDTH-1:0]              d,
   input  logic [WIDTH*DEPTH-1:0]        pdata,
   output logic [WIDTH*DEPTH-1:0]        q_all,
   output logic [WIDTH-1:0]              q_head,
   output logic [WIDTH-1:0]              q_tail,
   output logic [fill_width(DEPTH)-1:0]  fill,
   output logic                          full
);

   localparam int FW = fill_width(DEPTH);
   localparam logic [FW-1:0] FULL_CNT = FW'(DEPTH);

   mode_t                        op;
   logic                         rot_en;
   logic [DEPTH-1:0][WIDTH-1:0]  stg;
   logic [FW-1:0]                fill_nxt;

   assign op = mode_t'(mode);

`ifdef SHIFT_REG_BANK_ROTATE_EN
   assign rot_en = rot;
`else
   assign rot_en = 1'b0;
`endif

   // End stages take d on a plain shift, or wrap the opposite end when rotating.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      logic [WIDTH-1:0] left;
      logic [WIDTH-1:0] right;

      if (i == 0) begin : g_left_end
         assign left = rot_en ? stg[DEPTH-1] : d;
      end else begin : g_left_mid
         assign left = stg[i-1];
      end

      if (i == DEPTH-1) begin : g_right_end
         assign right = rot_en ? stg[0] : d;
      end else begin : g_right_mid
         assign right = stg[i+1];
      end

      shift_reg_stage #(.WIDTH(WIDTH)) u_stage (
         .clk   (clk),
         .reset (reset),
         .sel   (op),
         .left  (left),
         .right (right),
         .load  (pdata[i*WIDTH +: WIDTH]),
         .q     (stg[i])
      );
   end

   assign q_all  = stg;
   assign q_head = stg[0];
   assign q_tail = stg[DEPTH-1];

   always_comb begin
      fill_nxt = fill;
      case (op)
         MODE_LOAD: fill_nxt = FULL_CNT;
         MODE_SHL,
         MODE_SHR: begin
            if (!rot_en && fill != FULL_CNT) fill_nxt = fill + 1'b1;
         end
         default:   fill_nxt = fill;
      endcase
   end

   always_ff @(negedge clk or posedge reset) begin
      if (reset) fill <= '0;
      else       fill <= fill_nxt;
   end

   assign full = (fill == FULL_CNT);

endmodule

// File: tb/tb_shift_reg_bank.sv
// Scoreboard bench for shift_reg_bank (WIDTH=8, DEPTH=4); rotate cases need SHIFT_REG_BANK_ROTATE_EN.
module tb_shift_reg_bank;

   localparam logic [1:0] HOLD = 2'b00, SHL = 2'b01, SHR = 2'b10, LOAD = 2'b11;

   typedef struct {
      logic [31:0] q_all;
      logic [2:0]  fill;
   } exp_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [1:0]  mode = HOLD;
   logic        rot = 1'b0;
   logic [7:0]  d = '0;
   logic [31:0] pdata = '0;
   logic [31:0] q_all;
   logic [7:0]  q_head, q_tail;
   logic [2:0]  fill;
   logic        full;

   exp_t        exp_q[$];
   int          checks = 0;
   int          errors = 0;
   bit          chk_rise = 1'b0;

   always #5 clk = ~clk;

   shift_reg_bank #(.WIDTH(8), .DEPTH(4)) dut (
      .clk    (clk),
      .reset  (reset),
      .mode   (mode),
`ifdef SHIFT_REG_BANK_ROTATE_EN
      .rot    (rot),
`endif
      .d      (d),
      .pdata  (pdata),
      .q_all  (q_all),
      .q_head (q_head),
      .q_tail (q_tail),
      .fill   (fill),
      .full   (full)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
      end
   endtask

   task automatic check_zero(input string tag);
      check({tag, "_q_all"}, 64'(q_all), 64'h0);
      check({tag, "_fill"},  64'(fill),  64'h0);
      check({tag, "_full"},  64'(full),  64'h0);
   endtask

   // Called between a rising and falling edge; returns just after the next rising edge.
   task automatic step(input logic [1:0] m, input logic [7:0] dv, input logic [31:0] pd,
                       input logic r, input logic [31:0] eq, input logic [2:0] ef);
      exp_t e;
      mode = m; d = dv; pdata = pd; rot = r;
      e.q_all = eq; e.fill = ef;
      exp_q.push_back(e);
      @(negedge clk);
      @(posedge clk);
      #1;
   endtask

   // Monitor: outputs settle one falling edge after each issued operation.
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         #1;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("q_all",  64'(q_all),  64'(e.q_all));
            check("fill",   64'(fill),   64'(e.fill));
            check("full",   64'(full),   64'(e.fill == 3'd4));
            check("q_head", 64'(q_head), 64'(e.q_all[7:0]));
            check("q_tail", 64'(q_tail), 64'(e.q_all[31:24]));
         end
      end
   end

   initial begin
      logic [31:0] pre;
      forever begin
         @(negedge clk);
         #2;
         pre = q_all;
         @(posedge clk);
         #1;
         if (chk_rise) check("no_rise_change", 64'(q_all), 64'(pre));
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // Reset held while clocking with a live LOAD request
      mode = LOAD; pdata = 32'hFFFF_FFFF;
      repeat (3) @(negedge clk);
      #1 check_zero("rst_neg");
      @(posedge clk);
      #1 check_zero("rst_pos");
      reset = 1'b0;

      // SHL fill and saturation
      step(SHL, 8'h11, '0, 1'b0, 32'h0000_0011, 3'd1);
      step(SHL, 8'h22, '0, 1'b0, 32'h0000_1122, 3'd2);
      step(SHL, 8'h33, '0, 1'b0, 32'h0011_2233, 3'd3);
      step(SHL, 8'h44, '0, 1'b0, 32'h1122_3344, 3'd4);
      step(SHL, 8'h55, '0, 1'b0, 32'h2233_4455, 3'd4);

      // LOAD then SHR
      step(LOAD, 8'h00, 32'hA1B2_C3D4, 1'b0, 32'hA1B2_C3D4, 3'd4);
      step(SHR,  8'hEE, '0,            1'b0, 32'hEEA1_B2C3, 3'd4);

      // HOLD
      step(HOLD, 8'h99, 32'h5555_5555, 1'b0, 32'hEEA1_B2C3, 3'd4);
      step(HOLD, 8'h98, 32'h6666_6666, 1'b0, 32'hEEA1_B2C3, 3'd4);
      step(HOLD, 8'h97, 32'h7777_7777, 1'b0, 32'hEEA1_B2C3, 3'd4);

      // Reset between edges aborts a pending LOAD
      mode = LOAD; pdata = 32'h1234_5678;
      #1 reset = 1'b1;
      #1 check_zero("abort_now");
      @(negedge clk);
      #1 check_zero("abort_edge");
      @(posedge clk);
      #1 reset = 1'b0;

      // First edge after release executes the presented mode
      step(SHR,  8'h5A, '0, 1'b0, 32'h5A00_0000, 3'd1);
      step(HOLD, 8'hFF, '0, 1'b0, 32'h5A00_0000, 3'd1);
      step(SHR,  8'h6B, '0, 1'b0, 32'h6B5A_0000, 3'd2);

      // Mode sweep on consecutive edges; outputs must not move at rising edges
      chk_rise = 1'b1;
      step(HOLD, 8'h00, '0,            1'b0, 32'h6B5A_0000, 3'd2);
      step(SHL,  8'h01, '0,            1'b0, 32'h5A00_0001, 3'd3);
      step(SHR,  8'h02, '0,            1'b0, 32'h025A_0000, 3'd4);
      step(LOAD, 8'h00, 32'h0F0E_0D0C, 1'b0, 32'h0F0E_0D0C, 3'd4);
      chk_rise = 1'b0;

`ifdef SHIFT_REG_BANK_ROTATE_EN
      step(LOAD, 8'h00, 32'h0403_0201, 1'b0, 32'h0403_0201, 3'd4);
      step(SHL,  8'hAA, '0, 1'b1, 32'h0302_0104, 3'd4);
      step(SHL,  8'hAA, '0, 1'b1, 32'h0201_0403, 3'd4);
      step(SHL,  8'hAA, '0, 1'b1, 32'h0104_0302, 3'd4);
      step(SHL,  8'hAA, '0, 1'b1, 32'h0403_0201, 3'd4);
      step(SHR,  8'hBB, '0, 1'b1, 32'h0104_0302, 3'd4);

      // Rotation leaves a partial fill untouched and ignores d
      mode = HOLD;
      reset = 1'b1;
      #1 reset = 1'b0;
      step(SHL, 8'h99, '0, 1'b1, 32'h0000_0000, 3'd0);
      step(SHL, 8'h77, '0, 1'b0, 32'h0000_0077, 3'd1);
`endif

      for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(negedge clk);
      #3;
      check("drain", 64'(exp_q.size()), 64'h0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
